// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants for the pipeline stage register
//
// Holds the control FSM state encoding and the default payload value
// loaded on reset/flush. The stage top and its controller import it.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;   // no word held
    localparam logic [1:0] ST_BUSY  = 2'd1;   // one word in main register
    localparam logic [1:0] ST_FULL  = 2'd2;   // main and skid both hold words

    // MIPS NOP (sll $0,$0,0) - used as the squashed-instruction payload
    localparam logic [31:0] PIPE_NOP = 32'h0000_0000;

endpackage

// File: rtl/pipe_stage_ctrl.sv
// rtl/pipe_stage_ctrl.sv - handshake FSM for the 2-entry skid pipeline stage
//
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   flush          synchronous squash, overrides all handshakes
//   in_valid       upstream word valid
//   out_ready      downstream accepts
//   in_ready       registered ready toward upstream
//   out_valid      registered valid toward downstream
//   main_ld        load main register this edge
//   main_sel_skid  main register source: 1 = skid register, 0 = in_data
//   skid_ld        load skid register with in_data this edge
module pipe_stage_ctrl
    import pipe_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output logic main_ld,
    output logic main_sel_skid,
    output logic skid_ld
);

    logic [1:0] state_q, state_d;
    logic       in_ready_q;
    logic       out_valid_q;
    logic       acc;
    logic       pop;

    assign acc = in_valid & in_ready_q;
    assign pop = out_valid_q & out_ready;

    // in_ready/out_valid are derived from the next state and registered,
    // which keeps out_ready off any combinational path to in_ready.
    // in_ready stays low while reset is held and rises on the first edge after.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != ST_FULL);
            out_valid_q <= (state_d != ST_EMPTY);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (acc) state_d = ST_BUSY;
            ST_BUSY: begin
                if (acc && !pop)      state_d = ST_FULL;
                else if (!acc && pop) state_d = ST_EMPTY;
            end
            ST_FULL:  if (pop) state_d = ST_BUSY;
            default:  state_d = ST_EMPTY;
        endcase
        if (flush) state_d = ST_EMPTY;
    end

    always_comb begin
        main_ld       = 1'b0;
        skid_ld       = 1'b0;
        main_sel_skid = (state_q == ST_FULL);
        if (!flush) begin
            case (state_q)
                ST_EMPTY: main_ld = acc;
                ST_BUSY: begin
                    main_ld = acc & pop;
                    skid_ld = acc & ~pop;
                end
                ST_FULL:  main_ld = pop;
                default: ;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline register with 2-entry skid buffer
//
// Optional feature macro: PIPE_STAGE_STATS_EN (adds stall_cnt / flush_cnt).
// Parameters: WIDTH payload bits, RESET_VAL payload after reset/flush.
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   flush                 synchronous squash of all held words
//   in_valid/in_ready/in_data     upstream handshake (in_ready registered)
//   out_valid/out_ready/out_data  downstream handshake (out_data from main reg)
//   stall_cnt             cycles with out_valid & !out_ready (saturating)
//   flush_cnt             held words destroyed by flush (saturating)
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(PIPE_NOP)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt
`endif
);

    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             main_ld;
    logic             main_sel_skid;
    logic             skid_ld;

    pipe_stage_ctrl u_ctrl (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .out_ready     (out_ready),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .main_ld       (main_ld),
        .main_sel_skid (main_sel_skid),
        .skid_ld       (skid_ld)
    );

    // main_q is untouched on a pop to EMPTY, so out_data keeps showing the
    // last delivered word instead of going to RESET_VAL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q <= RESET_VAL;
            skid_q <= RESET_VAL;
        end else if (flush) begin
            main_q <= RESET_VAL;
            skid_q <= RESET_VAL;
        end else begin
            if (main_ld) main_q <= main_sel_skid ? skid_q : in_data;
            if (skid_ld) skid_q <= in_data;
        end
    end

    assign out_data = main_q;

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;
    logic [1:0]  held;
    logic [1:0]  dropped;
    logic [32:0] flush_sum;

    // Occupancy is recovered from the registered handshake outputs:
    // the stage is FULL exactly when it is valid but not ready.
    // Words accepted in the flush cycle were never held, so they are not counted.
    assign held      = {1'b0, out_valid} + {1'b0, out_valid & ~in_ready};
    assign dropped   = held - {1'b0, out_valid & out_ready};
    assign flush_sum = {1'b0, flush_cnt_q} + {31'd0, dropped};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush)
                flush_cnt_q <= flush_sum[32] ? 32'hFFFF_FFFF : flush_sum[31:0];
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

    localparam int          W  = 32;
    localparam logic [31:0] RV = 32'hDEAD_0001;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
`ifdef PIPE_STAGE_STATS_EN
    logic [31:0]   stall_cnt;
    logic [31:0]   flush_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the stage is a FIFO of at most two words.
    logic [31:0] mq[$];
    logic [31:0] m_last;
    bit          m_ready;
    longint      m_stall;
    longint      m_flush;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    function automatic logic [31:0] exp_data();
        return (mq.size() > 0) ? mq[0] : m_last;
    endfunction

    function automatic logic [31:0] sat32(input longint v);
        return (v > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    task automatic model_reset();
        mq.delete();
        m_last  = RV;
        m_ready = 1'b0;
        m_stall = 0;
        m_flush = 0;
    endtask

    // One clock: drive inputs (called at negedge), advance model, return at negedge.
    task automatic tick(input bit iv, input logic [31:0] d, input bit ordy, input bit fl);
        bit acc, pop;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        acc = iv && m_ready;
        pop = (mq.size() > 0) && ordy;
        if (mq.size() > 0 && !ordy) m_stall++;
        @(posedge clk);
        #1;
        if (pop) m_last = mq.pop_front();
        if (fl) begin
            m_flush += mq.size();
            mq.delete();
            m_last  = RV;
            m_ready = 1'b1;
        end else begin
            if (acc) mq.push_back(d);
            m_ready = (mq.size() < 2);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 0; flush = 0; out_ready = 0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_low got=%b exp=0", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        tick(0, 0, 0, 0);
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_rise got=%b exp=1", in_ready); end
        n_tests++; if (out_data !== RV) begin n_fail++; $display("FAIL rst_data got=%h exp=%h", out_data, RV); end
        // fill the stage, then reset asynchronously between edges
        tick(1, 32'h11, 0, 0);
        tick(1, 32'h22, 0, 0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready got=%b exp=0", in_ready); end
        n_tests++; if (out_data !== RV) begin n_fail++; $display("FAIL rst_mid_data got=%h exp=%h", out_data, RV); end
        @(negedge clk);
        reset = 1'b0;
        tick(0, 0, 1, 0);
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_rel_ready got=%b exp=1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rel_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_streaming();
        for (int k = 1; k <= 16; k++) begin
            tick(1, k, 1, 0);
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== k || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_%0d got v=%b d=%h r=%b exp v=1 d=%h r=1", k, out_valid, out_data, in_ready, k);
            end
        end
        tick(0, 0, 1, 0);
        n_tests++; if (out_valid !== 1'b0 || out_data !== 32'h10) begin n_fail++; $display("FAIL stream_end got v=%b d=%h exp v=0 d=10", out_valid, out_data); end
    endtask

    task automatic test_back_pressure();
        tick(1, 32'hA, 0, 0);
        n_tests++; if (out_data !== 32'hA || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_first got d=%h r=%b exp d=a r=1", out_data, in_ready); end
        tick(1, 32'hB, 0, 0);
        n_tests++; if (out_data !== 32'hA || in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_full got d=%h r=%b v=%b exp d=a r=0 v=1", out_data, in_ready, out_valid); end
        tick(1, 32'hC, 0, 0);
        n_tests++; if (out_data !== 32'hA || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold got d=%h r=%b exp d=a r=0", out_data, in_ready); end
        tick(0, 0, 1, 0);
        n_tests++; if (out_data !== 32'hB || in_ready !== 1'b1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_drain got d=%h r=%b v=%b exp d=b r=1 v=1", out_data, in_ready, out_valid); end
        tick(0, 0, 1, 0);
        n_tests++; if (out_valid !== 1'b0 || out_data !== 32'hB) begin n_fail++; $display("FAIL bp_empty got v=%b d=%h exp v=0 d=b", out_valid, out_data); end
    endtask

    task automatic test_flush_full();
        longint f0;
        tick(1, 32'h51, 0, 0);
        tick(1, 32'h52, 0, 0);
        f0 = m_flush;
        tick(1, 32'h53, 0, 1);
        n_tests++; if (out_valid !== 1'b0 || out_data !== RV || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_full got v=%b d=%h r=%b exp v=0 d=%h r=1", out_valid, out_data, in_ready, RV); end
        tick(0, 0, 1, 0);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_full_emit got v=%b exp 0", out_valid); end
        n_tests++; if (m_flush - f0 != 2) begin n_fail++; $display("FAIL flush_full_model got=%0d exp=2", m_flush - f0); end
`ifdef PIPE_STAGE_STATS_EN
        n_tests++; if (flush_cnt !== sat32(m_flush)) begin n_fail++; $display("FAIL flush_cnt_full got=%h exp=%h", flush_cnt, sat32(m_flush)); end
`endif
    endtask

    task automatic test_flush_pop();
        longint f0;
        tick(1, 32'h61, 0, 0);
        f0 = m_flush;
        tick(0, 0, 1, 1);
        n_tests++; if (out_valid !== 1'b0 || out_data !== RV || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_pop got v=%b d=%h r=%b exp v=0 d=%h r=1", out_valid, out_data, in_ready, RV); end
        n_tests++; if (m_flush != f0) begin n_fail++; $display("FAIL flush_pop_model got=%0d exp=%0d", m_flush, f0); end
`ifdef PIPE_STAGE_STATS_EN
        n_tests++; if (flush_cnt !== sat32(m_flush)) begin n_fail++; $display("FAIL flush_cnt_pop got=%h exp=%h", flush_cnt, sat32(m_flush)); end
`endif
    endtask

`ifdef PIPE_STAGE_STATS_EN
    task automatic test_stats();
        do_reset();
        tick(0, 0, 0, 0);
        tick(1, 32'h71, 0, 0);
        for (int i = 0; i < 5; i++) tick(0, 0, 0, 0);
        n_tests++; if (stall_cnt !== 32'd5) begin n_fail++; $display("FAIL stall_5 got=%0d exp=5", stall_cnt); end
        dut.stall_cnt_q = 32'hFFFF_FFFE;
        m_stall = 64'h0000_0000_FFFF_FFFE;
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
        n_tests++; if (stall_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL stall_sat got=%h exp=ffffffff", stall_cnt); end
        tick(0, 0, 1, 0);
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
            n_tests++;
            if (out_valid !== (mq.size() > 0) || in_ready !== m_ready || out_data !== exp_data()) begin
                n_fail++;
                $display("FAIL rand_%0d got v=%b r=%b d=%h exp v=%b r=%b d=%h", i, out_valid, in_ready, out_data,
                         mq.size() > 0, m_ready, exp_data());
            end
`ifdef PIPE_STAGE_STATS_EN
            n_tests++;
            if (stall_cnt !== sat32(m_stall) || flush_cnt !== sat32(m_flush)) begin
                n_fail++;
                $display("FAIL rand_cnt_%0d got s=%0d f=%0d exp s=%0d f=%0d", i, stall_cnt, flush_cnt, m_stall, m_flush);
            end
`endif
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush_full();
        test_flush_pop();
`ifdef PIPE_STAGE_STATS_EN
        test_stats();
`endif
        do_reset();
        tick(0, 0, 0, 0);
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
